// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, drives the combinational
// program ROM and queues {pc, instr} pairs for decode over valid/ready.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [31:0]                rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [31:0]                if_instr,
  output logic [31:0]                if_pc,
  output logic [$clog2(QDEPTH):0]    q_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  logic [31:0]   r_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pc_mem    [QDEPTH];
  logic [31:0]   r_instr_mem [QDEPTH];

  logic w_pop;
  logic w_push;

  // A pop frees its slot in the same cycle, so a full queue still accepts a push.
  assign w_pop  = (r_count != '0) & if_ready;
  assign w_push = fetch_en & ~redirect & ((r_count < DEPTH_C) | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect) begin
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc     <= r_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_pc;
      r_instr_mem[r_wr_ptr] <= rom_data;
    end
  end

  assign rom_addr = r_pc;
  assign if_valid = (r_count != '0);
  assign if_pc    = r_pc_mem[r_rd_ptr];
  assign if_instr = r_instr_mem[r_rd_ptr];
  assign q_count  = r_count;

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch controller sitting between the core's program counter logic and the combinational `Program_Rom`. It owns the fetch PC, drives the ROM address every cycle, captures returned instruction words with their PC into a small FIFO, and presents them to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be 0.
- `QDEPTH`, default 2: FIFO entries; power of two, range 2..8.

- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  1 = fetch allowed; 0 = no new pushes, FIFO still drains.
- `rom_addr`  out  32  to `Program_Rom` `Rom_addr`; equals the PC register.
- `rom_data`  in  32  from `Program_Rom` `Rom_data`; valid in the same cycle as `rom_addr`.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch.
- `redirect_pc`  in  32  target; bits [1:0] are ignored and forced to 0.
- `if_valid`  out  1  FIFO head valid.
- `if_ready`  in  1  decode accepts the head.
- `if_instr`  out  32  head instruction word.
- `if_pc`  out  32  head instruction address.
- `q_count`  out  $clog2(QDEPTH)+1  FIFO occupancy.

## Operation
- State: `pc` (32b), FIFO storage of {pc, instr} pairs, read pointer, write pointer, and count.
- `rom_addr = pc` combinationally from the register. There is no comb path from any input to `rom_addr`.
- `pop = if_valid & if_ready`.
- `push = fetch_en & ~redirect & (count < QDEPTH | pop)`. A pop frees its slot the same cycle, so a full FIFO sustains 1 instr/cycle.
- On push, write {pc, rom_data} at the write pointer and set `pc <= pc + 4` (32-bit wrap, 0xFFFF_FFFC -> 0).
- On pop, advance the read pointer.
- Count update: +1 on push only, -1 on pop only, unchanged on both.
- Pointers wrap modulo QDEPTH.
- Redirect has highest priority:
  - Count and both pointers are cleared, and `pc <= {redirect_pc[31:2], 2'b00}`.
  - No push that cycle.
  - A handshake completing in the redirect cycle counts as consumed by decode. The FIFO is cleared regardless.
- `fetch_en = 0`: `pc` holds, no push, pops proceed normally.
- `if_valid = (count != 0)`. `if_instr`/`if_pc` come from the head entry and are don't-care when `if_valid = 0`.
- Once asserted, `if_valid` and the head stay stable until popped or redirected.
- Addresses beyond the program return NOP (0x00000013) from the ROM. The controller treats these as ordinary instructions.

## Timing
- Reset values: `pc = RESET_PC`, `rom_addr = RESET_PC`, count 0, `if_valid = 0`, `q_count = 0`, pointers 0.
- A reset asserted mid-stream discards all entries on the next edge.
- `rst` overrides `redirect`.
- Fetch-to-decode latency is 1 cycle: word pushed at edge N is visible with `if_valid = 1` in cycle N+1.
- First instruction after reset release (`fetch_en = 1`): pushed at the first edge with `rst = 0`, and `if_valid = 1` the following cycle.
- Redirect penalty: redirect at edge N gives `if_valid = 0` in cycle N+1 and `rom_addr = target` in cycle N+1. The target instruction is presented in cycle N+2.
- Steady state with `if_ready = 1`: one instruction per cycle with consecutive PCs and no bubbles.
- Full (count = QDEPTH) with `if_ready = 0`: `pc` holds and `rom_addr` holds.
- Empty with `fetch_en = 0`: `if_valid` stays 0.

## Test plan
- Reset then stream: `rst` for 2 cycles, `fetch_en = 1`, `if_ready = 1` -> `if_pc`/`if_instr` = 0x0/0x341CE137, 0x4/0xF0C10113, 0x8/0x00202023 on consecutive cycles, `q_count` ≤ 1.
- Backpressure: `if_ready = 0` from reset -> `q_count` rises to 2 and stops, `rom_addr` freezes at 0x8, head stays 0x0/0x341CE137. Release `if_ready` -> 0x0, 0x4, 0x8 delivered back to back with no gap.
- Redirect: while streaming, pulse `redirect` with `redirect_pc = 0x9E` -> next cycle `if_valid = 0` and `rom_addr = 0x9C`; the cycle after, head = 0x9C/0xFC8294E3. No stale entry from before the redirect appears.
- Redirect while full, coincident with a pop: FIFO holds 2 entries, `if_ready = 1`, and `redirect` to 0x54 -> the popped entry counts as consumed, `q_count = 0` next cycle, then head = 0x54/0x00038103.
- Fetch gating and past-end fetch: `fetch_en = 0` with 2 entries queued and `if_ready = 1` -> drains to empty and `pc` holds. Redirect to 0xBC, `fetch_en = 1` -> 0xBC/0xFE021AE3 then 0xC0/0x00000013.
- Reset mid-operation: assert `rst` with `q_count = 2` and `pc = 0x40` -> next cycle `if_valid = 0`, `q_count = 0`, `rom_addr = RESET_PC`.
